// File: rtl/countdown_pkg.sv
// Shared encodings and constants for the MM:SS countdown sequencer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam int              BCD_W    = 8;
  localparam logic [BCD_W-1:0] SEC_WRAP = 8'h59;
  localparam logic [BCD_W-1:0] MIN_WRAP = 8'h99;
  localparam logic [15:0]      ZERO_VAL = 16'h0000;
  localparam logic [15:0]      ONE_VAL  = 16'h0001;

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD +1 with a configurable wrap point (59 for seconds, 99 for minutes).
module bcd2_inc
  import countdown_pkg::*;
#(
  parameter logic [BCD_W-1:0] WRAP = MIN_WRAP
) (
  input  logic [BCD_W-1:0] val,
  output logic [BCD_W-1:0] inc
);

  always_comb begin
    inc = '0;
    if (val == WRAP) begin
      inc = '0;
    end else if (val[3:0] == 4'd9) begin
      inc = {val[7:4] + 4'd1, 4'd0};
    end else begin
      inc = {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/clear/alarm sequencer for the BCD countdown datapath.
// Optional beep output enabled by defining COUNTDOWN_CTRL_BEEP_EN.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int               CNT_W        = 16,
  parameter logic [CNT_W-1:0] DEFAULT_LOAD = 16'h0100,
  parameter int               ALARM_SECS   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_ss,
  input  logic             btn_clr,
  input  logic             btn_min,
  input  logic             btn_sec,
  input  logic [CNT_W-1:0] cnt_value,
  output logic [CNT_W-1:0] cnt_load,
  output logic             cnt_loaden,
  output logic             cnt_dec,
  output logic             running,
  output logic             alarm,
  output logic [1:0]       state
`ifdef COUNTDOWN_CTRL_BEEP_EN
  ,
  output logic             beep
`endif
);

  localparam int AW = $clog2(ALARM_SECS + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic             loaden_q, loaden_d;
  logic             dec_q, dec_d;
  logic             running_q, running_d;
  logic             alarm_q, alarm_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic             rst_hold_q;
  logic [BCD_W-1:0] min_inc, sec_inc;
`ifdef COUNTDOWN_CTRL_BEEP_EN
  logic             beep_q, beep_d;
`endif

  bcd2_inc #(.WRAP(MIN_WRAP)) u_min_inc (.val(preset_q[15:8]), .inc(min_inc));
  bcd2_inc #(.WRAP(SEC_WRAP)) u_sec_inc (.val(preset_q[7:0]),  .inc(sec_inc));

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    // keeps the load strobe up for the first cycle out of reset
    loaden_d = rst_hold_q;
    dec_d    = 1'b0;
    acnt_d   = acnt_q;
`ifdef COUNTDOWN_CTRL_BEEP_EN
    beep_d   = beep_q;
`endif
    if (btn_clr) begin
      state_d  = ST_IDLE;
      loaden_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_ss) begin
            if (cnt_value != CNT_W'(ZERO_VAL)) state_d = ST_RUN;
          end else if (btn_min || btn_sec) begin
            if (btn_min) preset_d[15:8] = min_inc;
            if (btn_sec) preset_d[7:0]  = sec_inc;
            loaden_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (btn_ss) begin
            state_d = ST_PAUSE;
          end else if (cnt_value == CNT_W'(ZERO_VAL)) begin
            state_d = ST_ALARM;
          end else if (tick) begin
            dec_d = 1'b1;
            if (cnt_value == CNT_W'(ONE_VAL)) state_d = ST_ALARM;
          end
        end
        ST_PAUSE: begin
          if (btn_ss) state_d = ST_RUN;
        end
        ST_ALARM: begin
          if (btn_ss) begin
            state_d  = ST_IDLE;
            loaden_d = 1'b1;
          end else if (tick) begin
            acnt_d = acnt_q + AW'(1);
`ifdef COUNTDOWN_CTRL_BEEP_EN
            beep_d = ~beep_q;
`endif
            if (acnt_d == AW'(ALARM_SECS)) begin
              state_d  = ST_IDLE;
              loaden_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // counter and beep only live while staying in ALARM; cleared on entry and exit
    if (state_q != ST_ALARM || state_d != ST_ALARM) begin
      acnt_d = '0;
`ifdef COUNTDOWN_CTRL_BEEP_EN
      beep_d = 1'b0;
`endif
    end
    if (loaden_d) dec_d = 1'b0;
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      preset_q   <= DEFAULT_LOAD;
      loaden_q   <= 1'b1;
      dec_q      <= 1'b0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
      acnt_q     <= '0;
      rst_hold_q <= 1'b1;
`ifdef COUNTDOWN_CTRL_BEEP_EN
      beep_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      loaden_q   <= loaden_d;
      dec_q      <= dec_d;
      running_q  <= running_d;
      alarm_q    <= alarm_d;
      acnt_q     <= acnt_d;
      rst_hold_q <= 1'b0;
`ifdef COUNTDOWN_CTRL_BEEP_EN
      beep_q     <= beep_d;
`endif
    end
  end

  assign cnt_load   = preset_q;
  assign cnt_loaden = loaden_q;
  assign cnt_dec    = dec_q;
  assign running    = running_q;
  assign alarm      = alarm_q;
  assign state      = state_q;
`ifdef COUNTDOWN_CTRL_BEEP_EN
  assign beep       = beep_q;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl with a behavioural BCD countdown datapath.
module tb_countdown_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, btn_ss = 1'b0, btn_clr = 1'b0, btn_min = 1'b0, btn_sec = 1'b0;
  logic [15:0] cnt_value = 16'h0000;
  logic [15:0] cnt_load;
  logic        cnt_loaden, cnt_dec, running, alarm;
  logic [1:0]  state;
`ifdef COUNTDOWN_CTRL_BEEP_EN
  logic        beep;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  st;
    logic        ld;
    logic        dec;
    logic        alm;
    logic        bp;
    logic [15:0] load;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t me;

  countdown_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .btn_min(btn_min), .btn_sec(btn_sec), .cnt_value(cnt_value),
    .cnt_load(cnt_load), .cnt_loaden(cnt_loaden), .cnt_dec(cnt_dec),
    .running(running), .alarm(alarm), .state(state)
`ifdef COUNTDOWN_CTRL_BEEP_EN
    , .beep(beep)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd8(input int v);
    bcd8 = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    int t;
    t = (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    if (t > 0) t = t - 1;
    bcd_dec = {bcd8(t / 60), bcd8(t % 60)};
  endfunction

  // countdown datapath model
  always @(posedge clk) begin
    if (cnt_loaden)   cnt_value <= cnt_load;
    else if (cnt_dec) cnt_value <= bcd_dec(cnt_value);
  end

  // drive one cycle of inputs and queue the registered outputs expected after that edge
  task automatic cyc(input logic ss, clr, mn, sc, tk, rs,
                     input logic [1:0] st, input logic ld, dc, alm, bp,
                     input logic [15:0] load, input string nm);
    exp_t e;
    @(negedge clk);
    #2;
    btn_ss = ss; btn_clr = clr; btn_min = mn; btn_sec = sc; tick = tk; rst = rs;
    e.st = st; e.ld = ld; e.dec = dc; e.alm = alm; e.bp = bp; e.load = load; e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      checks++;
      if ({state, running, alarm, cnt_loaden, cnt_dec, cnt_load} !==
          {me.st, (me.st == 2'd1), me.alm, me.ld, me.dec, me.load}) begin
        errors++;
        $display("FAIL %s: got st=%0d run=%b alm=%b ld=%b dec=%b load=%h, want st=%0d run=%b alm=%b ld=%b dec=%b load=%h",
                 me.nm, state, running, alarm, cnt_loaden, cnt_dec, cnt_load,
                 me.st, (me.st == 2'd1), me.alm, me.ld, me.dec, me.load);
      end
`ifdef COUNTDOWN_CTRL_BEEP_EN
      checks++;
      if (beep !== me.bp) begin
        errors++;
        $display("FAIL %s_beep: got %b want %b", me.nm, beep, me.bp);
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and release
    cyc(0,0,0,0,0,1, 2'd0,1,0,0,0, 16'h0100, "reset0");
    cyc(0,0,0,0,0,1, 2'd0,1,0,0,0, 16'h0100, "reset1");
    cyc(0,0,0,0,0,0, 2'd0,1,0,0,0, 16'h0100, "reset_release");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0100, "idle_after_reset");
    // minutes 01 -> 99 -> 00
    for (int i = 1; i <= 98; i++)
      cyc(0,0,1,0,0,0, 2'd0,1,0,0,0, {bcd8(1 + i), 8'h00}, "min_inc");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h9900, "min99");
    cyc(0,0,1,0,0,0, 2'd0,1,0,0,0, 16'h0000, "min_wrap");
    // seconds 00 -> 59 -> 00
    for (int i = 1; i <= 59; i++)
      cyc(0,0,0,1,0,0, 2'd0,1,0,0,0, {8'h00, bcd8(i)}, "sec_inc");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0059, "sec59");
    cyc(0,0,0,1,0,0, 2'd0,1,0,0,0, 16'h0000, "sec_wrap");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0000, "idle_zero");
    cyc(1,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0000, "ss_zero_ignored");
    for (int i = 1; i <= 3; i++)
      cyc(0,0,0,1,0,0, 2'd0,1,0,0,0, {8'h00, bcd8(i)}, "sec_to_3");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0003, "idle_003");
    // run 00:03 down to alarm
    cyc(1,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "start");
    cyc(0,0,0,0,1,0, 2'd1,0,1,0,0, 16'h0003, "dec1");
    cyc(0,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "run_idle1");
    cyc(0,0,0,0,1,0, 2'd1,0,1,0,0, 16'h0003, "dec2");
    cyc(0,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "run_idle2");
    cyc(0,0,0,0,1,0, 2'd3,0,1,1,0, 16'h0003, "dec3_alarm");
    cyc(0,0,1,1,0,0, 2'd3,0,0,1,0, 16'h0003, "preset_in_alarm");
    for (int k = 1; k <= 9; k++)
      cyc(0,0,0,0,1,0, 2'd3,0,0,1,1'(k % 2), 16'h0003, "alarm_tick");
    cyc(0,0,0,0,1,0, 2'd0,1,0,0,0, 16'h0003, "alarm_timeout");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0003, "idle_after_alarm");
    // pause / resume
    cyc(1,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "start2");
    cyc(0,0,0,0,1,0, 2'd1,0,1,0,0, 16'h0003, "dec_p");
    cyc(1,0,0,0,1,0, 2'd2,0,0,0,0, 16'h0003, "ss_tick_pause");
    cyc(0,0,0,0,1,0, 2'd2,0,0,0,0, 16'h0003, "pause_tick1");
    cyc(0,0,0,0,1,0, 2'd2,0,0,0,0, 16'h0003, "pause_tick2");
    cyc(0,0,1,0,0,0, 2'd2,0,0,0,0, 16'h0003, "min_in_pause");
    cyc(1,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "resume");
    cyc(0,0,0,0,1,0, 2'd1,0,1,0,0, 16'h0003, "resume_dec");
    cyc(0,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "run_idle3");
    cyc(1,1,0,0,0,0, 2'd0,1,0,0,0, 16'h0003, "clr_ss_run");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0003, "idle_after_clr");
    // reach alarm again, then reset mid-alarm
    cyc(1,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "start3");
    cyc(0,0,0,0,1,0, 2'd1,0,1,0,0, 16'h0003, "dec_a1");
    cyc(0,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "run_idle4");
    cyc(0,0,0,0,1,0, 2'd1,0,1,0,0, 16'h0003, "dec_a2");
    cyc(0,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0003, "run_idle5");
    cyc(0,0,0,0,1,0, 2'd3,0,1,1,0, 16'h0003, "dec_a3_alarm");
    cyc(0,0,0,0,1,0, 2'd3,0,0,1,1, 16'h0003, "alarm2_tick1");
    cyc(0,0,0,0,1,0, 2'd3,0,0,1,0, 16'h0003, "alarm2_tick2");
    cyc(0,0,0,0,1,0, 2'd3,0,0,1,1, 16'h0003, "alarm2_tick3");
    cyc(0,0,0,0,1,1, 2'd0,1,0,0,0, 16'h0100, "rst_in_alarm");
    cyc(0,0,0,0,0,0, 2'd0,1,0,0,0, 16'h0100, "rst_release2");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0100, "idle_after_rst");
    // simultaneous preset buttons, clear in idle, clear from run
    cyc(0,0,1,1,0,0, 2'd0,1,0,0,0, 16'h0201, "min_sec_both");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0201, "idle_0201");
    cyc(0,1,0,0,0,0, 2'd0,1,0,0,0, 16'h0201, "clr_idle");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0201, "idle_after_clr2");
    cyc(1,0,0,0,0,0, 2'd1,0,0,0,0, 16'h0201, "start4");
    cyc(0,1,0,0,1,0, 2'd0,1,0,0,0, 16'h0201, "clr_tick_run");
    cyc(0,0,0,0,0,0, 2'd0,0,0,0,0, 16'h0201, "final_idle");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
